// File: rtl/muxn_reg_hs_if.sv
// Bundles the muxn_reg_hs channel bus: N input channels, select, registered output, error flag.
// master = producer/consumer side (drives channels, sel, out_ready); slave = the selector itself.
// err_count is present only when MUXN_ERRCNT_EN is defined.
interface muxn_reg_hs_if #(
  parameter int WIDTH = 16,
  parameter int N     = 5
);
  localparam int SELW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               sel_err;
`ifdef MUXN_ERRCNT_EN
  logic [15:0]        err_count;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, sel_err, err_count
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, sel_err, err_count
  );
`else
  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );
`endif
endinterface

// File: rtl/muxn_reg_hs.sv
// N-input WIDTH-bit selector with registered output and per-channel valid/ready handshake.
// Latency 1 cycle, 1 word/cycle throughput (accept and drain may share a cycle).
// Backpressure: out_valid & !out_ready holds the output word and deasserts every in_ready.
// Ports: clk, reset_n (async active-low), bus (muxn_reg_hs_if.slave: in_data/in_valid/in_ready,
//   sel, out_data/out_valid/out_ready, sel_err, err_count when MUXN_ERRCNT_EN is defined).
// MUXN_ERRCNT_EN: adds a saturating 16-bit count of sel_err pulses.
module muxn_reg_hs #(
  parameter int WIDTH = 16,
  parameter int N     = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  muxn_reg_hs_if.slave  bus
);
  localparam int SELW = $clog2(N);

  logic             slot_free;
  logic             sel_ok;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic [N-1:0]     rdy;
  logic             accept;
  logic             set_err;

  // Output register can take a new word when empty or being drained this cycle.
  assign slot_free = ~bus.out_valid | bus.out_ready;

  // With N a power of two every sel encoding names a real channel.
  generate
    if (N == (1 << SELW)) begin : g_sel_full
      assign sel_ok = 1'b1;
    end else begin : g_sel_part
      localparam logic [SELW:0] N_LIM = (SELW+1)'(N);
      assign sel_ok = ({1'b0, bus.sel} < N_LIM);
    end
  endgenerate

  // Decode the selected channel without ever indexing past N-1.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    rdy       = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.sel == SELW'(i)) begin
        sel_valid = bus.in_valid[i];
        sel_data  = bus.in_data[i*WIDTH +: WIDTH];
        rdy[i]    = slot_free & sel_ok;
      end
    end
  end

  assign bus.in_ready = rdy;
  assign accept       = slot_free & sel_ok & sel_valid;
  assign set_err      = slot_free & ~sel_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.sel_err   <= 1'b0;
    end else begin
      bus.sel_err <= set_err;
      if (slot_free) begin
        bus.out_valid <= accept;
        // Data keeps its last value on a bubble; only valid drops.
        if (accept) begin
          bus.out_data <= sel_data;
        end
      end
    end
  end

`ifdef MUXN_ERRCNT_EN
  // Counts in the same cycle sel_err is registered, so both rise together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.err_count <= '0;
    end else if (set_err && (bus.err_count != 16'hFFFF)) begin
      bus.err_count <= bus.err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_muxn_reg_hs.sv
// Bench for muxn_reg_hs: a 16x5 instance (directed + random) and a 32x8 instance.
// Reference model tracks the expected output slot per instance from the handshake rules.
module tb_muxn_reg_hs;
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muxn_reg_hs_if #(.WIDTH(16), .N(5)) ia ();
  muxn_reg_hs_if #(.WIDTH(32), .N(8)) ib ();

  muxn_reg_hs #(.WIDTH(16), .N(5)) dut_a (.clk(clk), .reset_n(rst_a), .bus(ia.slave));
  muxn_reg_hs #(.WIDTH(32), .N(8)) dut_b (.clk(clk), .reset_n(rst_b), .bus(ib.slave));

  // Model state: expected contents of each output slot.
  logic        ma_valid, ma_err;
  logic [15:0] ma_data, ma_cnt;
  logic        mb_valid, mb_err;
  logic [31:0] mb_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset_a();
    ma_valid = 1'b0; ma_err = 1'b0; ma_data = '0; ma_cnt = '0;
  endtask

  task automatic model_reset_b();
    mb_valid = 1'b0; mb_err = 1'b0; mb_data = '0;
  endtask

  // One clock: check combinational ready, advance, update model, check registered outputs.
  task automatic tick();
    int         sa, sb;
    bit         fa, fb;
    logic [7:0] va, vb;
    logic [7:0] ra, rb;
    logic       nva, nea, nvb, neb;
    logic [15:0] nda;
    logic [31:0] ndb;
    #1;
    sa = int'(ia.sel);
    sb = int'(ib.sel);
    va = 8'(ia.in_valid);
    vb = ib.in_valid;
    fa = !ma_valid || ia.out_ready;
    fb = !mb_valid || ib.out_ready;
    ra = (fa && sa < 5) ? 8'(1 << sa) : 8'h00;
    rb = fb ? 8'(1 << sb) : 8'h00;
    chk("a_in_ready", 32'(ia.in_ready), 32'(ra[4:0]));
    chk("b_in_ready", 32'(ib.in_ready), 32'(rb));

    nva = ma_valid; nda = ma_data; nea = 1'b0;
    if (fa) begin
      nva = (sa < 5) && va[sa];
      if (nva) nda = 16'(ia.in_data >> (sa * 16));
      nea = (sa >= 5);
    end
    nvb = mb_valid; ndb = mb_data; neb = 1'b0;
    if (fb) begin
      nvb = vb[sb];
      if (nvb) ndb = 32'(ib.in_data >> (sb * 32));
    end

    @(posedge clk);
    #1;
    if (!rst_a) model_reset_a();
    else begin
      ma_valid = nva; ma_data = nda; ma_err = nea;
      if (nea && ma_cnt != 16'hFFFF) ma_cnt = ma_cnt + 16'd1;
    end
    if (!rst_b) model_reset_b();
    else begin
      mb_valid = nvb; mb_data = ndb; mb_err = neb;
    end

    chk("a_out_valid", 32'(ia.out_valid), 32'(ma_valid));
    chk("a_out_data",  32'(ia.out_data),  32'(ma_data));
    chk("a_sel_err",   32'(ia.sel_err),   32'(ma_err));
`ifdef MUXN_ERRCNT_EN
    chk("a_err_count", 32'(ia.err_count), 32'(ma_cnt));
`endif
    chk("b_out_valid", 32'(ib.out_valid), 32'(mb_valid));
    chk("b_out_data",  32'(ib.out_data),  32'(mb_data));
    chk("b_sel_err",   32'(ib.sel_err),   32'(mb_err));
  endtask

  task automatic set_a(input int s, input logic [4:0] v, input int ch, input logic [15:0] d, input logic ordy);
    ia.sel = 3'(s);
    ia.in_valid = v;
    ia.in_data[ch*16 +: 16] = d;
    ia.out_ready = ordy;
  endtask

  initial begin
    ia.in_data = '0; ia.in_valid = '0; ia.sel = '0; ia.out_ready = 1'b1;
    ib.in_data = '0; ib.in_valid = '0; ib.sel = '0; ib.out_ready = 1'b1;
    model_reset_a();
    model_reset_b();

    // Reset state
    #12;
    chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
    chk("rst_out_data",  32'(ia.out_data),  32'd0);
    chk("rst_sel_err",   32'(ia.sel_err),   32'd0);
`ifdef MUXN_ERRCNT_EN
    chk("rst_err_count", 32'(ia.err_count), 32'd0);
`endif
    rst_a = 1'b1; rst_b = 1'b1;
    #4;

    // 1: single transfer from channel 2
    set_a(2, 5'b00100, 2, 16'hBEEF, 1'b1);
    #1;
    chk("t1_in_ready", 32'(ia.in_ready), 32'h04);
    tick();
    chk("t1_out_data",  32'(ia.out_data),  32'hBEEF);
    chk("t1_out_valid", 32'(ia.out_valid), 32'd1);

    // 2: back-to-back over all channels, no bubbles
    for (int i = 0; i < 5; i++) begin
      set_a(i, 5'(1 << i), i, 16'(i), 1'b1);
      tick();
      chk("t2_out_data",  32'(ia.out_data),  32'(i));
      chk("t2_out_valid", 32'(ia.out_valid), 32'd1);
    end

    // 3: stall with a held word while inputs churn
    set_a(1, 5'b00010, 1, 16'h1234, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_a(i, 5'b11111, i, 16'($urandom), 1'b0);
      tick();
      chk("t3_hold_data",  32'(ia.out_data),  32'h1234);
      chk("t3_hold_valid", 32'(ia.out_valid), 32'd1);
      chk("t3_no_ready",   32'(ia.in_ready),  32'd0);
    end
    set_a(4, 5'b10000, 4, 16'h5555, 1'b1);
    tick();
    chk("t3_next_data", 32'(ia.out_data), 32'h5555);

    // 4: out-of-range select with slot free
    set_a(6, 5'b11111, 0, 16'hAAAA, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t4_sel_err",   32'(ia.sel_err),   32'd1);
      chk("t4_out_valid", 32'(ia.out_valid), 32'd0);
    end
`ifdef MUXN_ERRCNT_EN
    chk("t4_err_count", 32'(ia.err_count), 32'd2);
`endif

    // 5: reset mid-stream discards the pending word at once
    set_a(0, 5'b00001, 0, 16'h7777, 1'b0);
    tick();
    chk("t5_pre_valid", 32'(ia.out_valid), 32'd1);
    rst_a = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(ia.out_valid), 32'd0);
    chk("t5_rst_data",  32'(ia.out_data),  32'd0);
    model_reset_a();
    tick();
    rst_a = 1'b1;
    set_a(3, 5'b01000, 3, 16'hC0DE, 1'b1);
    tick();
    chk("t5_resume", 32'(ia.out_data), 32'hC0DE);

    // Random traffic on the 5-channel instance, including out-of-range selects
    for (int n = 0; n < 300; n++) begin
      ia.sel = 3'($urandom_range(0, 7));
      ia.in_valid = 5'($urandom);
      ia.in_data = {$urandom, $urandom, $urandom};
      ia.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    ia.in_valid = '0;

    // 6: 32x8 instance, every channel passes data, sel_err never set
    for (int i = 0; i < 8; i++) begin
      ib.sel = 3'(i);
      ib.in_valid = 8'(1 << i);
      ib.in_data[i*32 +: 32] = 32'hA5000000 | 32'(i);
      ib.out_ready = 1'b1;
      tick();
      chk("t6_out_data", ib.out_data, 32'hA5000000 | 32'(i));
      chk("t6_sel_err",  32'(ib.sel_err), 32'd0);
    end
    for (int n = 0; n < 300; n++) begin
      ib.sel = 3'($urandom_range(0, 7));
      ib.in_valid = 8'($urandom);
      for (int k = 0; k < 8; k++) ib.in_data[k*32 +: 32] = $urandom;
      ib.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      chk("t6_rand_sel_err", 32'(ib.sel_err), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
